// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result queue: default word width, ALU control
// codes, the queue entry record and the occupancy state encoding.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [2:0] CTRL_AND = 3'b000;
    localparam logic [2:0] CTRL_OR  = 3'b001;
    localparam logic [2:0] CTRL_ADD = 3'b010;
    localparam logic [2:0] CTRL_SUB = 3'b110;
    localparam logic [2:0] CTRL_SLT = 3'b111;

    // Field order matches the flat storage word: {control, negative, zero, overflow, out}
    typedef struct packed {
        logic [2:0]           control;
        logic                 negative;
        logic                 zero;
        logic                 overflow;
        logic [ALU_WIDTH-1:0] out;
    } alu_entry_t;

    typedef enum logic [1:0] {
        Q_EMPTY   = 2'd0,
        Q_PARTIAL = 2'd1,
        Q_FULL    = 2'd2
    } occ_state_t;

endpackage

// File: rtl/alu_result_queue_if.sv
// Producer/consumer bundle of the ALU result queue. The slave modport is the
// queue's view; the master modport is the ALU and result consumer side.
interface alu_result_queue_if
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int DEPTH = 4
);
    logic                       in_valid;
    logic                       in_ready;
    logic [WIDTH-1:0]           in_out;
    logic                       in_overflow;
    logic                       in_zero;
    logic                       in_negative;
    logic [2:0]                 in_control;
    logic                       res_valid;
    logic                       res_ready;
    logic [WIDTH-1:0]           res_out;
    logic                       res_overflow;
    logic                       res_zero;
    logic                       res_negative;
    logic [2:0]                 res_control;
    logic [$clog2(DEPTH):0]     count;

    modport master (
        output in_valid, in_out, in_overflow, in_zero, in_negative, in_control, res_ready,
        input  in_ready, res_valid, res_out, res_overflow, res_zero, res_negative,
               res_control, count
    );

    modport slave (
        input  in_valid, in_out, in_overflow, in_zero, in_negative, in_control, res_ready,
        output in_ready, res_valid, res_out, res_overflow, res_zero, res_negative,
               res_control, count
    );

endinterface

// File: rtl/alu_fifo_mem.sv
// Queue storage: DEPTH words, one synchronous write port, one asynchronous read
// port. Contents are not reset; validity is tracked by the queue control.
module alu_fifo_mem #(
    parameter int EW    = 38,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [EW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [EW-1:0] rdata
);

    logic [EW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/alu_result_queue.sv
// FIFO of ALU results with flags and control tag. Optional overflow statistics
// (sticky flag and saturating counter) are built when ALU_STICKY_OVF_EN is defined.
//
// state     | meaning
// Q_EMPTY   | count == 0, res_valid low, head outputs forced to zero
// Q_PARTIAL | 0 < count < DEPTH, push and pop both possible
// Q_FULL    | count == DEPTH, in_ready low, only pops allowed
module alu_result_queue
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    alu_result_queue_if.slave   q
`ifdef ALU_STICKY_OVF_EN
    ,
    input  logic                clear_sticky,
    output logic                sticky_ovf,
    output logic [7:0]          ovf_count
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = WIDTH + 6;

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_q;
    occ_state_t    state;
    logic          in_ready_q, res_valid_q;
    logic          push, pop;
    logic [EW-1:0] wdata, rdata;

    // Handshakes use only registered status, so res_ready never reaches in_ready.
    assign push  = q.in_valid && in_ready_q;
    assign pop   = res_valid_q && q.res_ready;
    assign wdata = {q.in_control, q.in_negative, q.in_zero, q.in_overflow, q.in_out};

    alu_fifo_mem #(.EW(EW), .DEPTH(DEPTH), .AW(PW)) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wdata),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= Q_EMPTY;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b1;
            res_valid_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            unique case (state)
                Q_EMPTY: begin
                    if (push) begin
                        state       <= Q_PARTIAL;
                        res_valid_q <= 1'b1;
                    end
                end
                Q_PARTIAL: begin
                    if (push && !pop && count_q == CW'(DEPTH - 1)) begin
                        state      <= Q_FULL;
                        in_ready_q <= 1'b0;
                    end else if (pop && !push && count_q == CW'(1)) begin
                        state       <= Q_EMPTY;
                        res_valid_q <= 1'b0;
                    end
                end
                Q_FULL: begin
                    if (pop) begin
                        state      <= Q_PARTIAL;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state       <= Q_EMPTY;
                    in_ready_q  <= 1'b1;
                    res_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign q.in_ready     = in_ready_q;
    assign q.res_valid    = res_valid_q;
    assign q.count        = count_q;
    assign q.res_out      = res_valid_q ? rdata[WIDTH-1:0] : '0;
    assign q.res_overflow = res_valid_q & rdata[WIDTH];
    assign q.res_zero     = res_valid_q & rdata[WIDTH+1];
    assign q.res_negative = res_valid_q & rdata[WIDTH+2];
    assign q.res_control  = res_valid_q ? rdata[WIDTH+5:WIDTH+3] : 3'b000;

`ifdef ALU_STICKY_OVF_EN
    logic ovf_push;
    assign ovf_push = push && q.in_overflow;

    // A clear in the same cycle as an overflow push restarts the statistics at one event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sticky_ovf <= 1'b0;
            ovf_count  <= 8'd0;
        end else if (clear_sticky) begin
            sticky_ovf <= ovf_push;
            ovf_count  <= {7'd0, ovf_push};
        end else if (ovf_push) begin
            sticky_ovf <= 1'b1;
            if (ovf_count != 8'hFF) ovf_count <= ovf_count + 8'd1;
        end
    end
`endif

endmodule
